axi_mem_sequencer: RTL and testbench

- Arbitrates N simple requesters (C-side transactors, test stimulus) onto the single simplified AXI port of the AXI dummy memory.
- Converts one granted word request into an AW→W write sequence or an AR read sequence, then returns a response to that requester.
- Round-robin fairness; a per-transaction watchdog aborts hung handshakes. Sits between the requester mux and the memory's AWADDR/WDATA/ARADDR/RDATA/READY/VALID port.

---
 rtl/axi_mem_sequencer.sv | 123 ++++++++++++
 tb/tb_axi_mem_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_sequencer.sv
// axi_mem_sequencer: round-robin arbiter that turns one granted word request into an
// AW->W write or AR read on a simplified AXI port, with a per-handshake watchdog.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 8
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
module axi_mem_sequencer #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = `AXI_ADDR_W,
    parameter int DATA_W  = `AXI_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                     dut_clock,
    input  logic                     dut_rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        AWADDR,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [DATA_W-1:0]        WDATA,
    output logic                     WVALID,
    input  logic                     WREADY,
    output logic [ADDR_W-1:0]        ARADDR,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_W-1:0]        RDATA
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RESP} state_t;

    state_t            state, state_next;
    logic [PW-1:0]     rr_ptr, gnt, g_q, idx;
    logic [WW-1:0]     wd;
    logic              any_req, hs, expired;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[idx]) gnt = idx;
        end
    end

    assign any_req = |req_valid;
    assign expired = wd == WW'(TIMEOUT - 1);
    assign hs      = (state == WR_ADDR && AWREADY) || (state == WR_DATA && WREADY) ||
                     (state == RD_ADDR && ARREADY);
    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign WDATA   = wdata_q;

    always_ff @(posedge dut_clock or negedge dut_rst_n) begin
        if (!dut_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = !any_req ? IDLE : req_write[gnt] ? WR_ADDR : RD_ADDR;
            WR_ADDR: state_next = AWREADY ? WR_DATA : expired ? RESP : WR_ADDR;
            WR_DATA: state_next = (WREADY || expired) ? RESP : WR_DATA;
            RD_ADDR: state_next = (ARREADY || expired) ? RESP : RD_ADDR;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is combinational from req_valid, so it is masked while reset is held.
    always_comb begin
        req_ready = (state == IDLE && any_req && dut_rst_n) ? N_REQ'(1) << gnt : '0;
        rsp_valid = state == RESP ? N_REQ'(1) << g_q : '0;
        AWVALID   = state == WR_ADDR;
        WVALID    = state == WR_DATA;
        ARVALID   = state == RD_ADDR;
    end

    always_ff @(posedge dut_clock or negedge dut_rst_n) begin
        if (!dut_rst_n) begin
            rr_ptr    <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wd        <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            wd <= (state_next == state && state inside {WR_ADDR, WR_DATA, RD_ADDR}) ?
                  wd + WW'(1) : '0;
            if (state == IDLE && any_req) begin
                g_q     <= gnt;
                addr_q  <= addr_arr[gnt];
                wdata_q <= wdata_arr[gnt];
                rr_ptr  <= PW'((int'(gnt) + 1) % N_REQ);
            end
            // A handshake in the expiry cycle still wins; successful writes leave rdata alone.
            if (state != RESP && state_next == RESP) begin
                rsp_err <= !hs;
                if (state == RD_ADDR || !hs) rsp_rdata <= hs ? RDATA : '0;
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_sequencer.sv
// tb_axi_mem_sequencer: directed plus randomized checks of the sequencer against a
// transaction-level reference (round-robin pick, word memory, fixed latencies).
module tb_axi_mem_sequencer;
    localparam int N = 2, AW = 8, DW = 32, TO = 16;

    logic dut_clock = 0, dut_rst_n = 1;
    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, WDATA;
    logic            rsp_err, AWVALID, WVALID, ARVALID;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic            AWREADY = 0, WREADY = 0, ARREADY = 0;
    logic [DW-1:0]   RDATA = '0;

    axi_mem_sequencer #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .dut_clock(dut_clock), .dut_rst_n(dut_rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA));

    always #5 dut_clock = ~dut_clock;

    // Dummy memory: READY follows VALID by one cycle (so it also deasserts one cycle late).
    logic [DW-1:0] ram [2**AW];
    logic [AW-1:0] aw_lat = '0;
    bit stall = 0, aw_block = 0, ar_block = 0;
    always @(posedge dut_clock) begin
        AWREADY <= AWVALID && !aw_block && (!stall || $urandom_range(3) != 0);
        WREADY  <= WVALID && (!stall || $urandom_range(3) != 0);
        ARREADY <= ARVALID && !ar_block && (!stall || $urandom_range(3) != 0);
        RDATA   <= ram[ARADDR];
        if (AWVALID && AWREADY) aw_lat <= AWADDR;
        if (WVALID && WREADY) ram[aw_lat] <= WDATA;
    end

    // Reference: one transaction at a time, strict round-robin, word-addressed memory.
    logic [DW-1:0] ref_mem [2**AW];
    int total = 0, bad = 0, cyc = 0, rr = 0, pg = 0, t0 = 0, lat = 0, g = 0;
    bit busy = 0, pw = 0, perr = 0, lat_chk = 1;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [N-1:0]  exp_rdy, last_rdy = '0;
    logic [DW-1:0] last_rdata = '0;
    bit last_err = 0;
    int last_lat = 0;
    int dq[$];

    task automatic check(string name, logic [127:0] got, logic [127:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s got=%0h need=%0h (t=%0t)", name, got, need, $time);
        end
    endtask

    task automatic expire(string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(negedge dut_clock) begin
        cyc++;
        if (!dut_rst_n) begin
            check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, AWVALID, WVALID,
                                    ARVALID, AWADDR, ARADDR, WDATA}, '0);
            busy = 0;
            rr = 0;
            last_rdy = '0;
        end else begin
            g = busy ? -1 : pick(req_valid, rr);
            exp_rdy = g < 0 ? '0 : N'(1) << g;
            check("req_ready", req_ready, exp_rdy);
            check("aw_w_overlap", AWVALID && WVALID, 0);
            for (int k = 0; k < N; k++) if (req_ready[k]) dq.push_back(k);
            if (rsp_valid !== '0) begin
                if (!busy) check("rsp_unexpected", rsp_valid, 0);
                else begin
                    lat = cyc - t0;
                    check("rsp_valid", rsp_valid, N'(1) << pg);
                    check("rsp_err", rsp_err, perr);
                    if (!pw) check("rsp_rdata", rsp_rdata, perr ? '0 : ref_mem[pa]);
                    if (lat_chk) check("latency", lat, perr ? TO + 1 : pw ? 5 : 3);
                    if (pw && !perr) ref_mem[pa] = pd;
                    last_rdata = rsp_rdata;
                    last_err = rsp_err;
                    last_lat = lat;
                    busy = 0;
                end
            end else if (busy && cyc - t0 > 200) begin
                expire("rsp_wait");
                busy = 0;
            end
            if (g >= 0) begin
                busy = 1;
                pg = g;
                pw = req_write[g];
                pa = req_addr[g*AW +: AW];
                pd = req_wdata[g*DW +: DW];
                perr = pw ? aw_block : ar_block;
                t0 = cyc;
                rr = (g + 1) % N;
            end
            last_rdy = req_ready;
        end
    end

    task automatic drive(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i] = 1;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_rsp(int i);
        for (int c = 0; c < 100; c++) begin
            @(negedge dut_clock);
            if (rsp_valid[i]) begin
                #1;
                return;
            end
        end
        expire("wait_rsp");
    endtask

    task automatic wait_grants(int n);
        for (int c = 0; c < 100; c++) begin
            @(negedge dut_clock);
            #1;
            if (dq.size() >= n) return;
        end
        expire("wait_grants");
    endtask

    task automatic txn(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        bit got = 0;
        @(posedge dut_clock);
        #1;
        drive(i, w, a, d);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge dut_clock);
            got = req_ready[i];
        end
        if (!got) expire("grant_wait");
        @(posedge dut_clock);
        #1;
        req_valid[i] = 0;
        wait_rsp(i);
    endtask

    initial begin
        for (int a = 0; a < 2**AW; a++) begin
            ram[a] = '0;
            ref_mem[a] = '0;
        end
        #1 dut_rst_n = 0;
        repeat (3) @(posedge dut_clock);
        #1 dut_rst_n = 1;

        // Contention from rr_ptr=0: grants alternate 0,1,0,1
        dq.delete();
        @(posedge dut_clock);
        #1;
        drive(0, 1, 8'h01, 32'h1111_1111);
        drive(1, 1, 8'h02, 32'h2222_2222);
        wait_grants(4);
        @(posedge dut_clock);
        #1;
        req_valid = '0;
        wait_rsp(1);
        check("rr_order0", dq[0], 0);
        check("rr_order1", dq[1], 1);
        check("rr_order2", dq[2], 0);
        check("rr_order3", dq[3], 1);
        txn(0, 0, 8'h01, 0);
        check("contend_rd1", last_rdata, 32'h1111_1111);
        txn(1, 0, 8'h02, 0);
        check("contend_rd2", last_rdata, 32'h2222_2222);

        // Single write then read with minimum latencies
        txn(0, 1, 8'h10, 32'hDEAD_BEEF);
        check("wr_lat", last_lat, 5);
        check("wr_err", last_err, 0);
        txn(0, 0, 8'h10, 0);
        check("rd_data", last_rdata, 32'hDEAD_BEEF);
        check("rd_lat", last_lat, 3);
        check("rd_err", last_err, 0);

        // Address extremes do not alias
        txn(0, 1, 8'hFF, 32'h55);
        txn(1, 1, 8'h00, 32'hAA);
        txn(0, 0, 8'hFF, 0);
        check("wrap_hi", last_rdata, 32'h55);
        txn(1, 0, 8'h00, 0);
        check("wrap_lo", last_rdata, 32'hAA);

        // Write timeout leaves memory untouched; read timeout returns zero data
        aw_block = 1;
        txn(0, 1, 8'h30, 32'h77);
        check("to_err", last_err, 1);
        check("to_lat", last_lat, 17);
        check("to_awvalid", AWVALID, 0);
        aw_block = 0;
        txn(0, 0, 8'h30, 0);
        check("to_unwritten", last_rdata, 0);
        check("to_next_err", last_err, 0);
        ar_block = 1;
        txn(1, 0, 8'h10, 0);
        check("rto_err", last_err, 1);
        check("rto_data", last_rdata, 0);
        ar_block = 0;

        // Withdrawn req1 pulse while req0 is busy
        dq.delete();
        @(posedge dut_clock);
        #1;
        drive(0, 1, 8'h40, 32'h4444);
        wait_grants(1);
        @(posedge dut_clock);
        #1;
        req_valid[0] = 0;
        drive(1, 0, 8'h10, 0);
        @(posedge dut_clock);
        #1;
        req_valid[1] = 0;
        wait_rsp(0);
        check("withdraw_grants", dq.size(), 1);
        @(posedge dut_clock);
        #1;
        drive(0, 0, 8'h40, 0);
        drive(1, 0, 8'h10, 0);
        wait_grants(2);
        check("withdraw_rr", dq[1], 1);
        @(posedge dut_clock);
        #1;
        req_valid[1] = 0;
        wait_grants(3);
        @(posedge dut_clock);
        #1;
        req_valid[0] = 0;
        wait_rsp(0);
        check("withdraw_rd", last_rdata, 32'h4444);

        // Reset while ARVALID is high
        @(posedge dut_clock);
        #1;
        drive(1, 0, 8'h02, 0);
        wait_grants(4);
        @(posedge dut_clock);
        #1;
        req_valid[1] = 0;
        begin
            bit seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge dut_clock);
                seen = ARVALID;
            end
            if (!seen) expire("arvalid_wait");
        end
        #1 dut_rst_n = 0;
        #1;
        check("async_arvalid", ARVALID, 0);
        check("async_rsp", rsp_valid, 0);
        repeat (3) @(posedge dut_clock);
        #1 dut_rst_n = 1;
        txn(1, 0, 8'h02, 0);
        check("post_reset_rd", last_rdata, 32'h2222_2222);
        check("post_reset_err", last_err, 0);

        // Randomized traffic with memory back-pressure
        lat_chk = 0;
        stall = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge dut_clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (last_rdy[i] || !req_valid[i]) begin
                    req_valid[i] = last_rdy[i] ? bit'($urandom_range(1)) : ($urandom_range(2) == 0);
                    req_write[i] = bit'($urandom_range(1));
                    req_addr[i*AW +: AW] = $urandom_range(3) == 0 ? AW'($urandom) : AW'($urandom_range(7));
                    req_wdata[i*DW +: DW] = $urandom;
                end else if ($urandom_range(15) == 0) req_valid[i] = 0;
            end
        end
        @(posedge dut_clock);
        #1;
        req_valid = '0;
        for (int c = 0; c < 200 && busy; c++) @(negedge dut_clock);
        if (busy) expire("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
